// File: rtl/dump_pkg.sv
// Shared constants and FSM state type for the trace dump sequencer.
package dump_pkg;
  localparam int DUMP_ADDR_W = 9;
  localparam int DUMP_DEPTH  = 512;
  localparam int DUMP_DATA_W = 8;
  localparam int NUM_CH      = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CAP,
    ST_RD,
    ST_LATCH,
    ST_SEND,
    ST_WAIT_TX,
    ST_FIN
  } dump_state_t;
endpackage

// File: rtl/dump_addr_ctr.sv
// Read address walker: loads the oldest-sample address, steps with wrap,
// and counts samples so the FSM knows when the last one has been sent.
module dump_addr_ctr #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [ADDR_W:0] cnt;

  // DEPTH is a power of two, so the natural rollover of addr is the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= start_addr;
      cnt  <= '0;
    end else if (step) begin
      addr <= addr + 1'b1;
      cnt  <= cnt + 1'b1;
    end
  end

  assign last = (cnt == (ADDR_W+1)'(DEPTH - 1));
endmodule

// File: rtl/trace_dump_sequencer.sv
// Streams one captured channel trace from capture RAM to the UART
// transmitter, oldest sample first, one byte per start/done handshake.
module trace_dump_sequencer #(
  parameter int ADDR_W = dump_pkg::DUMP_ADDR_W,
  parameter int DEPTH  = dump_pkg::DUMP_DEPTH,
  parameter int DATA_W = dump_pkg::DUMP_DATA_W,
  parameter int NUM_CH = dump_pkg::NUM_CH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_req,
  input  logic [1:0]        dump_ch,
  input  logic              dump_abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              cap_busy,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [1:0]        ram_ch,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              dump_busy,
  output logic              dump_fin,
  output logic              dump_err
);
  import dump_pkg::*;

  localparam logic [2:0] CH_LIMIT = 3'(NUM_CH);

  dump_state_t state, state_nx;
  logic        ch_valid;
  logic        load;
  logic        step;
  logic        last;
  logic [1:0]  ch_q;

  assign ch_valid = ({1'b0, dump_ch} < CH_LIMIT);

  dump_addr_ctr #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_ctr (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .start_addr (start_addr),
    .step       (step),
    .addr       (ram_addr),
    .last       (last)
  );

  // Abort is only looked at on tx_done so the byte on the wire always completes.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dump_req && ch_valid) begin
          state_nx = ST_WAIT_CAP;
          load     = 1'b1;
        end
      end
      ST_WAIT_CAP: if (!cap_busy) state_nx = ST_RD;
      ST_RD:       state_nx = ST_LATCH;
      ST_LATCH:    state_nx = ST_SEND;
      ST_SEND:     state_nx = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (tx_done) begin
          step = 1'b1;
          if (last || dump_abort) state_nx = ST_FIN;
          else if (cap_busy)      state_nx = ST_WAIT_CAP;
          else                    state_nx = ST_RD;
        end
      end
      ST_FIN:      state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ch_q     <= '0;
      tx_data  <= '0;
      dump_err <= 1'b0;
    end else begin
      state    <= state_nx;
      dump_err <= (state == ST_IDLE) && dump_req && !ch_valid;
      if (load)
        ch_q <= dump_ch;
      if (state == ST_LATCH)
        tx_data <= ram_rdata;
    end
  end

  assign ram_en    = (state == ST_RD);
  assign tx_start  = (state == ST_SEND);
  assign dump_fin  = (state == ST_FIN);
  assign dump_busy = (state != ST_IDLE);
  assign ram_ch    = ch_q;
endmodule

// File: tb/tb_trace_dump_sequencer.sv
// Randomized self-checking bench: RAM and transmitter models plus a
// reference of which bytes and addresses a dump should produce.
module tb_trace_dump_sequencer;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              dump_req = 1'b0;
  logic [1:0]        dump_ch = '0;
  logic              dump_abort = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              cap_busy = 1'b0;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_ch;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_done = 1'b0;
  logic              dump_busy;
  logic              dump_fin;
  logic              dump_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]        mem [0:3][0:DEPTH-1];
  logic [7:0]        tx_q [$];
  logic [ADDR_W-1:0] addr_q [$];
  int                fin_cnt, err_cnt, viol_cnt, ch_err, dbl_pulse;
  logic [1:0]        exp_ch = '0;
  logic              busy_mode = 1'b0;
  logic              prev_start = 1'b0, prev_fin = 1'b0, prev_err = 1'b0;

  always #5 clk = ~clk;

  trace_dump_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .dump_req   (dump_req),
    .dump_ch    (dump_ch),
    .dump_abort (dump_abort),
    .start_addr (start_addr),
    .cap_busy   (cap_busy),
    .ram_en     (ram_en),
    .ram_addr   (ram_addr),
    .ram_ch     (ram_ch),
    .ram_rdata  (ram_rdata),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_done    (tx_done),
    .dump_busy  (dump_busy),
    .dump_fin   (dump_fin),
    .dump_err   (dump_err)
  );

  // Synchronous-read capture RAM: data one cycle after ram_en.
  always @(posedge clk)
    if (ram_en) ram_rdata <= mem[ram_ch][ram_addr];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearMonitor();
    tx_q.delete();
    addr_q.delete();
    fin_cnt = 0; err_cnt = 0; viol_cnt = 0; ch_err = 0; dbl_pulse = 0;
  endtask

  // Observes every DUT event on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) tx_q.push_back(tx_data);
      if (ram_en) begin
        addr_q.push_back(ram_addr);
        if (ram_ch !== exp_ch) ch_err++;
        if (cap_busy) viol_cnt++;
      end
      if (dump_fin) fin_cnt++;
      if (dump_err) err_cnt++;
      if ((tx_start && prev_start) || (dump_fin && prev_fin) || (dump_err && prev_err)) dbl_pulse++;
      prev_start = tx_start;
      prev_fin   = dump_fin;
      prev_err   = dump_err;
    end
  end

  // Transmitter: tx_done a few clocks after tx_start; optionally grabs RAM meanwhile.
  initial begin
    int busy_hold;
    forever begin
      @(negedge clk);
      if (tx_start && !rst) begin
        busy_hold = 0;
        repeat (2) @(negedge clk);
        if (busy_mode && $urandom_range(0, 2) == 0) begin
          cap_busy  = 1'b1;
          busy_hold = $urandom_range(1, 6);
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        if (busy_hold > 0) begin
          repeat (busy_hold) @(negedge clk);
          cap_busy = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] ch, input logic [ADDR_W-1:0] start,
                               input int abort_at, input int req_busy, input logic bmode);
    int cyc;
    int n_exp;
    int a;
    clearMonitor();
    exp_ch    = ch;
    busy_mode = bmode;
    @(negedge clk);
    dump_ch    = ch;
    start_addr = start;
    dump_req   = 1'b1;
    if (req_busy > 0) cap_busy = 1'b1;
    @(negedge clk);
    dump_req   = 1'b0;
    dump_ch    = 2'($urandom);
    start_addr = ADDR_W'($urandom);
    checkOutput("busy_after_req", 32'(dump_busy), 32'd1);
    if (req_busy > 0) begin
      if (req_busy > 1) repeat (req_busy - 1) @(negedge clk);
      cap_busy = 1'b0;
      @(negedge clk);
      checkOutput("first_rd_after_cap", 32'(ram_en), 32'd1);
    end
    cyc = 0;
    while (fin_cnt == 0 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (abort_at >= 0 && tx_q.size() > abort_at) dump_abort = 1'b1;
      dump_req = (abort_at >= 10) && (cyc == 40 || cyc == 60);
      if (dump_req) begin
        dump_ch    = (cyc == 40) ? 2'd3 : 2'd2;
        start_addr = '0;
      end
    end
    dump_req   = 1'b0;
    dump_abort = 1'b0;
    checkOutput("dump_fin_seen", 32'(fin_cnt != 0), 32'd1);
    repeat (12) @(negedge clk);
    n_exp = (abort_at >= 0) ? abort_at + 1 : DEPTH;
    checkOutput("fin_count", fin_cnt, 1);
    checkOutput("err_count", err_cnt, 0);
    checkOutput("rd_while_cap_busy", viol_cnt, 0);
    checkOutput("ram_ch_held", ch_err, 0);
    checkOutput("pulse_width", dbl_pulse, 0);
    checkOutput("tx_count", tx_q.size(), n_exp);
    checkOutput("rd_count", addr_q.size(), n_exp);
    checkOutput("idle_after_fin", 32'(dump_busy), 32'd0);
    for (int i = 0; i < n_exp && i < tx_q.size() && i < addr_q.size(); i++) begin
      a = (int'(start) + i) % DEPTH;
      checkOutput("tx_byte", 32'(tx_q[i]), 32'(mem[ch][a]));
      checkOutput("rd_addr", 32'(addr_q[i]), a);
    end
  endtask

  initial begin
    int cyc;
    int busy_seen;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < DEPTH; i++)
        mem[c][i] = (c == 1) ? 8'(i) : 8'($urandom);

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(dump_busy), 0);
    checkOutput("rst_ram_en", 32'(ram_en), 0);
    checkOutput("rst_tx_start", 32'(tx_start), 0);
    checkOutput("rst_fin", 32'(dump_fin), 0);
    checkOutput("rst_err", 32'(dump_err), 0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 0);
    checkOutput("rst_tx_data", 32'(tx_data), 0);
    rst = 1'b0;

    // Full wrap-around dump, channel 1 holds address-pattern data.
    applyStimulus(2'd1, 9'h1F0, -1, 0, 1'b0);

    // Invalid channel request.
    clearMonitor();
    @(negedge clk);
    dump_ch = 2'd3; dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    busy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (dump_busy) busy_seen++;
    end
    checkOutput("err_pulse_count", err_cnt, 1);
    checkOutput("err_busy", busy_seen, 0);
    checkOutput("err_no_read", addr_q.size(), 0);
    checkOutput("err_pulse_width", dbl_pulse, 0);

    // Capture holds the RAM for 20 clocks at request time.
    applyStimulus(2'd2, ADDR_W'($urandom), -1, 20, 1'b0);

    // Abort during byte 10, with stray requests mid-dump.
    applyStimulus(2'd0, ADDR_W'($urandom), 10, 0, 1'b0);

    // Reset in WAIT_TX of byte 100.
    clearMonitor();
    exp_ch = 2'd0; busy_mode = 1'b0;
    @(negedge clk);
    dump_ch = 2'd0; start_addr = ADDR_W'($urandom); dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    cyc = 0;
    while (tx_q.size() < 101 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("reached_byte_100", 32'(tx_q.size() >= 101), 1);
    @(negedge clk);
    checkOutput("pre_rst_busy", 32'(dump_busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", 32'(dump_busy), 0);
    checkOutput("mid_rst_ram_en", 32'(ram_en), 0);
    checkOutput("mid_rst_tx_start", 32'(tx_start), 0);
    checkOutput("mid_rst_fin", 32'(dump_fin), 0);
    checkOutput("mid_rst_ram_ch", 32'(ram_ch), 0);
    checkOutput("mid_rst_tx_data", 32'(tx_data), 0);
    repeat (6) @(negedge clk);
    checkOutput("mid_rst_no_fin", fin_cnt, 0);
    rst = 1'b0;
    applyStimulus(2'd0, ADDR_W'($urandom), -1, 0, 1'b0);

    // Randomized dumps with capture interference and random aborts.
    repeat (6) begin
      applyStimulus(2'($urandom_range(0, 2)), ADDR_W'($urandom),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : -1,
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0,
                    1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
